// File: rtl/systemspec_pkg.sv
// ============================================================================
//  Module   : systemspec_pkg
//  Desc     : Shared opcode constants and FSM state encoding for systemspec.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package systemspec_pkg;

    // Opcode encoding, formed as {a, b}
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    // Two-state control FSM
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : systemspec_pkg

`default_nettype wire

// File: rtl/systemspec_mul.sv
// ============================================================================
//  Module   : systemspec_mul
//  Desc     : Iterative shift-and-add multiplier, one multiplier bit per step,
//             LSB first. Product is truncated to W bits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module systemspec_mul #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic         step,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product
);

    logic [W-1:0] mcand_q, mcand_d;
    logic [W-1:0] mplier_q, mplier_d;
    logic [W-1:0] prod_q, prod_d;
    logic [W-1:0] addend_w;
    logic [W-1:0] sum_w;

    // Partial product for the current multiplier bit; product presents the
    // accumulated value including this step, so the final step's result is
    // visible at the same edge that retires it.
    always_comb begin
        addend_w = mplier_q[0] ? mcand_q : '0;
        sum_w    = prod_q + addend_w;
        product  = sum_w;
    end

    // Next-state: load operands on init, otherwise shift one bit per step
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (init) begin
            mcand_d  = a;
            mplier_d = b;
            prod_d   = '0;
        end else if (step) begin
            prod_d   = sum_w;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    // Datapath registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

endmodule : systemspec_mul

`default_nettype wire

// File: rtl/systemspec.sv
// ============================================================================
//  Module   : systemspec
//  Desc     : Multi-cycle accumulator ALU. Each accepted operation spends
//             exactly W BUSY cycles, then writes load/add/sub/mul into z.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module systemspec
    import systemspec_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         a,
    input  logic         b,
    input  logic [W-1:0] x,
    output logic         ready,
    output logic [W-1:0] z
);

    localparam int           CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  zc_q, zc_d;
    logic [W-1:0]  z_q, z_d;

    logic          accept_w;
    logic          busy_w;
    logic          last_w;
    logic [W-1:0]  prod_w;
    logic [W-1:0]  result_w;

    assign accept_w = (state_q == IDLE) && start;
    assign busy_w   = (state_q == BUSY);
    assign last_w   = busy_w && (cnt_q == LAST);

    // Multiplier is seeded from the live z/x at the accept edge, so its
    // operands match the captured copies used by the other opcodes.
    systemspec_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .init    (accept_w),
        .step    (busy_w),
        .a       (z_q),
        .b       (x),
        .product (prod_w)
    );

    // Result select from captured opcode; arithmetic wraps modulo 2^W
    always_comb begin
        result_w = x_q;
        case (op_q)
            OP_LOAD: result_w = x_q;
            OP_ADD:  result_w = zc_q + x_q;
            OP_SUB:  result_w = zc_q - x_q;
            OP_MUL:  result_w = prod_w;
            default: result_w = x_q;
        endcase
    end

    // FSM next-state, capture, counter and result write-back
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        x_d     = x_q;
        zc_d    = zc_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = {a, b};
                    x_d     = x;
                    zc_d    = z_q;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == LAST) begin
                    z_d     = result_w;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            x_q     <= '0;
            zc_q    <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            x_q     <= x_d;
            zc_q    <= zc_d;
            z_q     <= z_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign z     = z_q;

    // last_w documents the retiring cycle; kept for readability of the FSM
    logic unused_w;
    assign unused_w = last_w;

endmodule : systemspec

`default_nettype wire

// File: tb/tb_systemspec.sv
// ============================================================================
//  Module   : tb_systemspec
//  Desc     : Self-checking bench for systemspec (W=4): table vectors,
//             randomized ops against a reference model, and corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_systemspec;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         a;
    logic         b;
    logic [W-1:0] x;
    logic         ready;
    logic [W-1:0] z;

    int total;
    int bad;
    logic [W-1:0] mz;

    systemspec #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .x     (x),
        .ready (ready),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [3:0] xv;
        logic [3:0] exp;
        bit         tog;
    } vec_t;

    vec_t tbl[9];

    // Reference: opcode rules in plain integer arithmetic, wrapped to 2^W
    function automatic logic [3:0] ref_op(input logic [1:0] op,
                                          input logic [3:0] zz,
                                          input logic [3:0] xx);
        int r;
        case (op)
            2'd0:    r = int'(xx);
            2'd1:    r = int'(zz) + int'(xx);
            2'd2:    r = int'(zz) - int'(xx) + 16;
            default: r = int'(zz) * int'(xx);
        endcase
        return 4'(r % 16);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present an op and take it through the accept edge
    task automatic issue(input logic [1:0] op, input logic [3:0] xv);
        start = 1'b1;
        {a, b} = op;
        x = xv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Observe the BUSY window: length, z held, then final z
    task automatic finish_op(input logic [3:0] exp, input bit tog, input string nm);
        int cycles;
        bit held;
        logic [3:0] z0;
        cycles = 0;
        held = 1'b1;
        z0 = z;
        forever begin
            @(negedge clk);
            if (ready) break;
            cycles++;
            if (z != z0) held = 1'b0;
            if (tog) begin
                a = 1'($urandom);
                b = 1'($urandom);
                x = 4'($urandom);
                start = 1'($urandom);
            end
            if (cycles > 20) break;
        end
        start = 1'b0;
        chk({nm, "_latency"}, cycles, W);
        chk({nm, "_zheld"}, int'(held), 1);
        chk({nm, "_z"}, int'(z), int'(exp));
    endtask

    task automatic do_op(input logic [1:0] op, input logic [3:0] xv,
                         input logic [3:0] exp, input bit tog, input string nm);
        @(negedge clk);
        chk({nm, "_ready_pre"}, int'(ready), 1);
        issue(op, xv);
        finish_op(exp, tog, nm);
        mz = exp;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        mz    = '0;
        start = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        x     = '0;
        rst   = 1'b1;

        // Reset values are visible before any clock edge
        #1;
        chk("rst_async_ready", int'(ready), 1);
        chk("rst_async_z", int'(z), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", int'(ready), 1);
        chk("post_rst_z", int'(z), 0);

        // Directed vectors from z=0
        tbl[0] = '{2'b01, 4'd6,  4'd6,  1'b0};
        tbl[1] = '{2'b10, 4'd5,  4'd1,  1'b0};
        tbl[2] = '{2'b10, 4'd3,  4'd14, 1'b0};
        tbl[3] = '{2'b00, 4'd6,  4'd6,  1'b0};
        tbl[4] = '{2'b11, 4'd6,  4'd4,  1'b0};
        tbl[5] = '{2'b00, 4'd1,  4'd1,  1'b0};
        tbl[6] = '{2'b11, 4'd11, 4'd11, 1'b0};
        tbl[7] = '{2'b00, 4'd9,  4'd9,  1'b1};
        tbl[8] = '{2'b11, 4'd15, 4'd7,  1'b1};
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].op, tbl[i].xv, tbl[i].exp, tbl[i].tog, $sformatf("vec%0d", i));
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [3:0] xv;
            op = 2'($urandom_range(0, 3));
            xv = 4'($urandom);
            do_op(op, xv, ref_op(op, mz, xv), 1'($urandom), $sformatf("rnd%0d", i));
        end

        // Reset mid-BUSY aborts immediately
        do_op(2'b00, 4'd7, 4'd7, 1'b0, "preload");
        @(negedge clk);
        issue(2'b01, 4'd3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_z", int'(z), 0);
        @(negedge clk);
        // First edge after release accepts
        rst = 1'b0;
        mz = '0;
        start = 1'b1;
        {a, b} = 2'b01;
        x = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_after_rst", int'(ready), 0);
        finish_op(ref_op(2'b01, mz, 4'd5), 1'b0, "after_rst");
        mz = ref_op(2'b01, mz, 4'd5);

        // Back-to-back adds of 1 from z=0 with start held high
        do_op(2'b00, 4'd0, 4'd0, 1'b0, "clear");
        @(negedge clk);
        start = 1'b1;
        {a, b} = 2'b01;
        x = 4'd1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready%0d", k), int'(ready), int'((k % (W + 1)) == 0));
            chk($sformatf("b2b_z%0d", k), int'(z), k / (W + 1));
        end
        start = 1'b0;
        begin
            int guard;
            guard = 0;
            while (!ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("b2b_drain_ready", int'(ready), 1);
            chk("b2b_final_z", int'(z), 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_systemspec

`default_nettype wire
